mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_ctrl.sv | 113 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - iterative 16x16 shift-add multiplier sharing an external 16-bit adder
// Optional early termination on exhausted multiplier bits: define MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  // One-hot-style encoding so busy/done are single flop bits.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               early_exit;
  logic [2*WIDTH-1:0] early_product;

`ifdef MUL_EARLY_TERM_EN
  logic [5:0]         early_shamt;
  logic [2*WIDTH-1:0] early_acc;

  // After cnt iterations only lo[15-cnt:0] still holds multiplier bits.
  assign early_acc     = {hi_q, lo_q};
  assign early_shamt   = 6'd16 - {1'b0, cnt_q};
  assign early_exit    = ((lo_q & (16'hFFFF >> cnt_q)) == '0);
  assign early_product = early_acc >> early_shamt;
`else
  assign early_exit    = 1'b0;
  assign early_product = '0;
`endif

  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    add_a     = '0;
    add_b     = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mc_d    = mcand;
          hi_d    = '0;
          lo_d    = mplier;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (early_exit) begin
          product_d = early_product;
          state_d   = ST_DONE;
        end else begin
          add_a = hi_q;
          add_b = lo_q[0] ? mc_q : '0;
          hi_d  = {add_cout, add_sum[WIDTH-1:1]};
          lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            product_d = {add_cout, add_sum, lo_q[WIDTH-1:1]};
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mc_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = state_q[0];
  assign done    = state_q[1];
  assign product = product_q;
  assign add_cin = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl with a behavioural product/latency model
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mcand = '0;
  logic [15:0] mplier = '0;
  logic        busy, done;
  logic [31:0] product;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  bit cout_seen = 1'b0;

  typedef struct {
    logic [31:0] prod;
    int          acc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  mul_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // The shared ripple-carry adder that sits outside the controller.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_lat(input logic [15:0] b);
`ifdef MUL_EARLY_TERM_EN
    for (int i = 15; i >= 0; i--)
      if (b[i]) return (i + 2 > 16) ? 16 : i + 2;
    return 1;
`else
    return 16;
`endif
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    check("add_cin", {31'b0, add_cin}, 32'd0);
    if (!busy) begin
      check("add_a_idle", {16'b0, add_a}, 32'd0);
      check("add_b_idle", {16'b0, add_b}, 32'd0);
    end else if (add_cout) begin
      cout_seen = 1'b1;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", product, e.prod);
        check("latency", cyc - e.acc, e.lat);
        check("busy_len", busy_cnt, e.lat);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("idle_wait_timeout", 32'd1, 32'd0);
    mcand = a;
    mplier = b;
    start = 1'b1;
    e.prod = {16'b0, a} * {16'b0, b};
    e.acc = cyc + 1;
    e.lat = model_lat(b);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mcand = 16'($urandom);
    mplier = 16'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] a, b;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_add_a", {16'b0, add_a}, 32'd0);
    check("rst_add_b", {16'b0, add_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_product", product, 32'd0);

    issue(16'd3, 16'd5);
    drain();
    check("prod_3x5", product, 32'h0000000F);

    cout_seen = 1'b0;
    issue(16'hFFFF, 16'hFFFF);
    drain();
    check("prod_ffff_sq", product, 32'hFFFE0001);
    check("cout_seen", {31'b0, cout_seen}, 32'd1);

    // A start pulse while running must be ignored.
    issue(16'h1234, 16'h0010);
    repeat (2) @(negedge clk);
    mcand = 16'd7;
    mplier = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("prod_repulse", product, 32'h00012340);
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    issue(16'hFFFF, 16'h00FF);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_product", product, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'd2, 16'd3);
    drain();
    check("prod_2x3", product, 32'd6);

    issue(16'hABCD, 16'h0001);
    issue(16'h5A5A, 16'h0000);
    issue(16'h1357, 16'h8000);
    drain();
    check("prod_last_8000", product, 32'h09AB8000);

    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom);
        1: b = 16'($urandom) & ((16'd1 << $urandom_range(0, 15)) - 16'd1);
        2: b = 16'd0;
        default: b = 16'd1 << $urandom_range(0, 15);
      endcase
      issue(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
